thread_rr_sched: RTL and testbench

// Round-robin thread scheduler that sits upstream of the per-thread state table.
// It scans thread states through the table's asynchronous read channel #1 and finds
// the next thread in MATCH_STATE. It claims that thread by writing CLAIM_STATE through

---
 rtl/thread_rr_sched.sv | 118 +++++++++++
 tb/tb_thread_rr_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_rr_sched.sv
// Round-robin thread scheduler: scans the thread state table for MATCH_STATE,
// claims the thread by writing CLAIM_STATE, then offers it over valid/ready.
module thread_rr_sched #(
  parameter int unsigned        N_THREADS     = 6,
  parameter int unsigned        N_THREADS_MSB = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0,
  parameter int unsigned        STATE_W       = 3,
  parameter logic [STATE_W-1:0] MATCH_STATE   = STATE_W'(2),
  parameter logic [STATE_W-1:0] CLAIM_STATE   = STATE_W'(0)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   en,
  output logic [N_THREADS_MSB:0] rd_num,
  input  logic [STATE_W-1:0]     rd_state,
  output logic                   wr_en,
  output logic [N_THREADS_MSB:0] wr_num,
  output logic [STATE_W-1:0]     wr_state,
  output logic                   valid,
  output logic [N_THREADS_MSB:0] thread_num,
  input  logic                   ready,
  output logic                   idle
);

  localparam int unsigned NUM_W = N_THREADS_MSB + 1;

  typedef logic [NUM_W-1:0] num_t;
  typedef enum logic {SCAN, OFFER} state_e;

  localparam num_t LAST = num_t'(N_THREADS - 1);

  state_e state_q, state_d;
  num_t   ptr_q, ptr_d;
  num_t   miss_q, miss_d;
  logic   wr_en_q, wr_en_d;
  num_t   wr_num_q, wr_num_d;
  logic   valid_q, valid_d;
  num_t   thread_num_q, thread_num_d;
  logic   idle_q, idle_d;

  // Pointer increment with wrap for non-power-of-2 thread counts
  function automatic num_t inc_wrap(input num_t n);
    return (n == LAST) ? '0 : n + num_t'(1);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= SCAN;
      ptr_q        <= '0;
      miss_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_num_q     <= '0;
      valid_q      <= 1'b0;
      thread_num_q <= '0;
      idle_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      miss_q       <= miss_d;
      wr_en_q      <= wr_en_d;
      wr_num_q     <= wr_num_d;
      valid_q      <= valid_d;
      thread_num_q <= thread_num_d;
      idle_q       <= idle_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    miss_d       = miss_q;
    wr_en_d      = 1'b0;
    wr_num_d     = wr_num_q;
    valid_d      = valid_q;
    thread_num_d = thread_num_q;
    idle_d       = idle_q;
    case (state_q)
      SCAN: begin
        if (en) begin
          if (rd_state == MATCH_STATE) begin
            wr_en_d      = 1'b1;
            wr_num_d     = ptr_q;
            thread_num_d = ptr_q;
            valid_d      = 1'b1;
            idle_d       = 1'b0;
            miss_d       = '0;
            state_d      = OFFER;
          end else begin
            ptr_d = inc_wrap(ptr_q);
            // A full round of misses marks the table idle
            if (miss_q == LAST) begin
              idle_d = 1'b1;
              miss_d = '0;
            end else begin
              miss_d = miss_q + num_t'(1);
            end
          end
        end
      end
      OFFER: begin
        if (ready) begin
          valid_d = 1'b0;
          ptr_d   = inc_wrap(thread_num_q);
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign rd_num     = ptr_q;
  assign wr_en      = wr_en_q;
  assign wr_num     = wr_num_q;
  assign wr_state   = CLAIM_STATE;
  assign valid      = valid_q;
  assign thread_num = thread_num_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_thread_rr_sched.sv
// Bench for thread_rr_sched: directed vectors and corner sequences, then random
// traffic against a state-table model and an integer reference model.
module tb_thread_rr_sched;

  localparam int N  = 6;
  localparam int SW = 3;
  localparam logic [SW-1:0] MATCH = 3'd2;
  localparam logic [SW-1:0] CLAIM = 3'd0;

  typedef logic [N-1:0][SW-1:0] tbl_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          en;
  logic [2:0]    rd_num;
  logic [SW-1:0] rd_state;
  logic          wr_en;
  logic [2:0]    wr_num;
  logic [SW-1:0] wr_state;
  logic          valid;
  logic [2:0]    thread_num;
  logic          ready;
  logic          idle;

  tbl_t tbl;
  tbl_t tb_vals;
  logic tb_load;

  int n_chk  = 0;
  int n_fail = 0;

  thread_rr_sched #(
    .N_THREADS  (N),
    .STATE_W    (SW),
    .MATCH_STATE(MATCH),
    .CLAIM_STATE(CLAIM)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .en        (en),
    .rd_num    (rd_num),
    .rd_state  (rd_state),
    .wr_en     (wr_en),
    .wr_num    (wr_num),
    .wr_state  (wr_state),
    .valid     (valid),
    .thread_num(thread_num),
    .ready     (ready),
    .idle      (idle)
  );

  always #5 CLK = ~CLK;

  // Thread state table: async read, write lands before the next scan can reach it
  assign rd_state = tbl[rd_num];
  always @(posedge CLK) begin
    if (tb_load) tbl <= tb_vals;
    if (wr_en) tbl[wr_num] <= wr_state;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic tbl_t fill(input logic [SW-1:0] base, input int match_idx);
    tbl_t t;
    for (int i = 0; i < N; i++) t[i] = (i == match_idx) ? MATCH : base;
    return t;
  endfunction

  // Returns at a negedge with reset applied and the table loaded; RST still high
  task automatic do_reset(input tbl_t v);
    @(negedge CLK);
    RST = 1'b1; en = 1'b0; ready = 1'b0;
    tb_vals = v; tb_load = 1'b1;
    @(negedge CLK);
    tb_load = 1'b0;
  endtask

  typedef struct {
    logic en; logic rdy; logic ld;
    int rd; int wr; int vld; int tn;
  } vec_t;
  vec_t vecs [14];

  // Reference model state (integer view of the scheduler)
  int m_ptr, m_miss, m_wn, m_tn;
  bit m_idle, m_valid, m_wr;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bit r_rst;
    tbl_t all_match;
    RST = 1'b1; en = 1'b0; ready = 1'b0; tb_load = 1'b0; tb_vals = '0;
    all_match = fill(MATCH, -1);

    // Back-to-back claims with ready held high
    for (int i = 0; i < 14; i++) begin
      vecs[i].en  = 1'b1;
      vecs[i].rdy = 1'b1;
      vecs[i].ld  = (i == 11);
      vecs[i].rd  = (i / 2) % N;
      vecs[i].wr  = i % 2;
      vecs[i].vld = i % 2;
      vecs[i].tn  = (i % 2 == 1) ? (i / 2) % N : ((i < 2) ? 0 : (i / 2 - 1) % N);
    end

    do_reset(all_match);
    chk("rst_valid", int'(valid), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_rd_num", int'(rd_num), 0);
    chk("rst_wr_num", int'(wr_num), 0);
    chk("rst_thread_num", int'(thread_num), 0);
    chk("rst_idle", int'(idle), 0);
    chk("wr_state_const", int'(wr_state), int'(CLAIM));

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("vec%0d_rd_num", i), int'(rd_num), vecs[i].rd);
      chk($sformatf("vec%0d_wr_en", i), int'(wr_en), vecs[i].wr);
      chk($sformatf("vec%0d_valid", i), int'(valid), vecs[i].vld);
      chk($sformatf("vec%0d_thread_num", i), int'(thread_num), vecs[i].tn);
      chk($sformatf("vec%0d_wr_num", i), int'(wr_num), vecs[i].tn);
      chk($sformatf("vec%0d_idle", i), int'(idle), 0);
      RST = 1'b0; en = vecs[i].en; ready = vecs[i].rdy;
      tb_vals = all_match; tb_load = vecs[i].ld;
      @(negedge CLK);
      tb_load = 1'b0;
    end

    // Only thread 4 matches: scan walks 0..4, then stall the consumer
    do_reset(fill(3'd1, 4));
    RST = 1'b0; en = 1'b1; ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4_scan%0d_rd_num", c), int'(rd_num), c);
      chk($sformatf("t4_scan%0d_valid", c), int'(valid), 0);
      @(negedge CLK);
    end
    chk("t4_claim_valid", int'(valid), 1);
    chk("t4_claim_thread_num", int'(thread_num), 4);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      pulses += int'(wr_en);
      chk($sformatf("hold%0d_thread_num", c), int'(thread_num), 4);
      chk($sformatf("hold%0d_valid", c), int'(valid), 1);
      @(negedge CLK);
    end
    chk("hold_wr_en_pulses", pulses, 1);
    ready = 1'b1;
    tb_vals = fill(3'd1, 5); tb_load = 1'b1;
    @(negedge CLK);
    tb_load = 1'b0;
    chk("after_t4_rd_num", int'(rd_num), 5);
    chk("after_t4_valid", int'(valid), 0);
    @(negedge CLK);
    chk("t5_valid", int'(valid), 1);
    chk("t5_thread_num", int'(thread_num), 5);
    @(negedge CLK);
    chk("t5_wrap_rd_num", int'(rd_num), 0);
    chk("t5_wrap_valid", int'(valid), 0);

    // Scan enable low freezes the pointer, then resumes from it
    en = 1'b0; ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk($sformatf("en0_%0d_rd_num", c), int'(rd_num), 0);
      chk($sformatf("en0_%0d_wr_en", c), int'(wr_en), 0);
    end
    en = 1'b1;
    @(negedge CLK);
    chk("en1_resume_rd_num", int'(rd_num), 1);
    @(negedge CLK);
    chk("en1_resume2_rd_num", int'(rd_num), 2);

    // Idle after a full empty round; a match clears it; reset mid-offer
    do_reset(fill(3'd1, -1));
    RST = 1'b0; en = 1'b1; ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("idle_c%0d", c), int'(idle), 0);
      @(negedge CLK);
    end
    chk("idle_c6", int'(idle), 1);
    tb_vals = fill(3'd1, 2); tb_load = 1'b1;
    @(negedge CLK);
    tb_load = 1'b0;
    chk("idle_held", int'(idle), 1);
    for (int k = 0; k < 20 && valid !== 1'b1; k++) @(negedge CLK);
    chk("idle_claim_valid", int'(valid), 1);
    chk("idle_claim_idle", int'(idle), 0);
    chk("idle_claim_thread_num", int'(thread_num), 2);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_offer_valid", int'(valid), 0);
    chk("rst_offer_rd_num", int'(rd_num), 0);
    chk("rst_offer_wr_en", int'(wr_en), 0);
    chk("rst_offer_idle", int'(idle), 0);

    // Random traffic against the reference model
    begin
      tbl_t rv;
      for (int i = 0; i < N; i++)
        rv[i] = ($urandom_range(0, 3) == 0) ? MATCH : SW'($urandom_range(0, 7));
      do_reset(rv);
    end
    RST = 1'b0;
    m_ptr = 0; m_miss = 0; m_wn = 0; m_tn = 0;
    m_idle = 0; m_valid = 0; m_wr = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_rd_num", int'(rd_num), m_ptr);
      chk("rnd_wr_en", int'(wr_en), int'(m_wr));
      chk("rnd_wr_num", int'(wr_num), m_wn);
      chk("rnd_valid", int'(valid), int'(m_valid));
      chk("rnd_thread_num", int'(thread_num), m_tn);
      chk("rnd_idle", int'(idle), int'(m_idle));
      r_rst = ($urandom_range(0, 299) == 0);
      RST   = r_rst;
      en    = ($urandom_range(0, 7) != 0);
      ready = ($urandom_range(0, 2) != 0);
      tb_load = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++)
        tb_vals[i] = ($urandom_range(0, 3) == 0) ? MATCH : SW'($urandom_range(0, 7));
      if (r_rst) begin
        m_ptr = 0; m_miss = 0; m_wn = 0; m_tn = 0;
        m_idle = 0; m_valid = 0; m_wr = 0;
      end else begin
        m_wr = 0;
        if (!m_valid) begin
          if (en) begin
            if (tbl[m_ptr] == MATCH) begin
              m_wr = 1; m_wn = m_ptr; m_tn = m_ptr;
              m_valid = 1; m_idle = 0; m_miss = 0;
            end else begin
              m_ptr = (m_ptr + 1) % N;
              m_miss++;
              if (m_miss == N) begin
                m_idle = 1; m_miss = 0;
              end
            end
          end
        end else if (ready) begin
          m_valid = 0;
          m_ptr = (m_tn + 1) % N;
        end
      end
      @(negedge CLK);
      tb_load = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
